// File: rtl/wave_sequencer.sv
// wave_sequencer: drives the Functions lookup (f_sel/index), steps a phase
// accumulator at a divided sample rate and holds each looked-up value in a
// valid/ready output register. Function changes made while running are
// deferred to the next phase wrap.
// Ports:
//   CLK, reset (async, active-low)
//   start/stop                control levels
//   f_req/f_req_valid         function request strobe
//   step/div                  phase increment and rate divider, latched at start
//   value_in                  lookup result for the presented f_sel/index
//   f_sel/index               lookup select and address
//   sample/sample_valid/sample_ready   output handshake
//   loop                      pulse, in step with the first post-wrap index
//   f_pending/busy            status
module wave_sequencer #(
    parameter int ACC_W   = 16,
    parameter int INDEX_W = 8,
    parameter int DIV_W   = 16
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         f_req,
    input  logic               f_req_valid,
    input  logic [ACC_W-1:0]   step,
    input  logic [DIV_W-1:0]   div,
    input  logic               sample_ready,
    input  logic [7:0]         value_in,
    output logic [1:0]         f_sel,
    output logic [INDEX_W-1:0] index,
    output logic [7:0]         sample,
    output logic               sample_valid,
    output logic               loop,
    output logic               f_pending,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] DIV_ONE = 1;

    state_t             r_state;
    state_t             w_next;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_step;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   r_tcnt;
    logic [1:0]         r_f_sel;
    logic [1:0]         r_f_pend_val;
    logic               r_f_pending;
    logic [7:0]         r_sample;
    logic               r_sample_valid;
    logic               r_loop;

    logic [ACC_W:0]     w_sum;
    logic               w_out_free;
    logic               w_tick;
    logic               w_wrap;
    logic               w_to_idle;

    assign w_sum = {1'b0, r_acc} + {1'b0, r_step};

    // State register
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start)      w_next = S_RUN;
            S_RUN:   if (stop)       w_next = S_DRAIN;
            S_DRAIN: if (w_out_free) w_next = S_IDLE;
            default:                 w_next = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        // The output slot can take a new value when empty or being accepted.
        w_out_free = !r_sample_valid || sample_ready;
        w_tick     = (r_state == S_RUN) && (r_tcnt == r_div) && w_out_free;
        w_wrap     = w_tick && w_sum[ACC_W];
        w_to_idle  = (r_state == S_DRAIN) && w_out_free;
        busy       = (r_state != S_IDLE);
    end

    // Phase accumulator and rate divider
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_acc  <= '0;
            r_tcnt <= '0;
            r_step <= '0;
            r_div  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_acc  <= '0;
                    r_tcnt <= '0;
                    if (start) begin
                        r_step <= step;
                        r_div  <= div;
                    end
                end
                S_RUN: begin
                    // At terminal count the divider waits for the slot.
                    if (w_tick) begin
                        r_acc  <= w_sum[ACC_W-1:0];
                        r_tcnt <= '0;
                    end else if (r_tcnt != r_div) begin
                        r_tcnt <= r_tcnt + DIV_ONE;
                    end
                end
                S_DRAIN: begin
                    if (w_out_free) begin
                        r_acc  <= '0;
                        r_tcnt <= '0;
                    end
                end
                default: begin
                    r_acc  <= '0;
                    r_tcnt <= '0;
                end
            endcase
        end
    end

    // Output register and wrap pulse
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_loop         <= 1'b0;
        end else begin
            r_loop <= w_wrap;
            if (w_tick) begin
                r_sample       <= value_in;
                r_sample_valid <= 1'b1;
            end else if (sample_ready) begin
                r_sample_valid <= 1'b0;
            end
        end
    end

    // Function select with deferral while running
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_f_sel      <= '0;
            r_f_pend_val <= '0;
            r_f_pending  <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (w_wrap && r_f_pending) begin
                r_f_sel <= r_f_pend_val;
            end
            // A request on the wrap edge is held for the following wrap.
            if (f_req_valid) begin
                r_f_pend_val <= f_req;
                r_f_pending  <= 1'b1;
            end else if (w_wrap) begin
                r_f_pending  <= 1'b0;
            end
        end else if (f_req_valid) begin
            r_f_sel     <= f_req;
            r_f_pending <= 1'b0;
        end else if (w_to_idle && r_f_pending) begin
            r_f_sel     <= r_f_pend_val;
            r_f_pending <= 1'b0;
        end
    end

    assign f_sel        = r_f_sel;
    assign index        = r_acc[ACC_W-1 -: INDEX_W];
    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign loop         = r_loop;
    assign f_pending    = r_f_pending;

endmodule
